// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser: assembles status/data bytes with running
// status, ignores real-time bytes, and presents each message on a held valid/ready register.
module midi_msg_parser #(
  parameter bit         OMNI        = 1'b1,
  parameter logic [3:0] CHANNEL     = 4'd0,
  parameter bit         VEL0_AS_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_in_valid,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [2:0] msg_type,
  output logic [3:0] msg_chan,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic [7:0] drop_cnt
);

  // Handshake: a message transfers on any cycle where msg_valid & msg_ready;
  // while msg_valid & ~msg_ready the message outputs hold their values.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] run_q, run_d;
  logic [6:0] d1_q, d1_d;

  logic       is_rt;
  logic       two_bytes;
  logic       done;
  logic [6:0] done_d1;
  logic [6:0] done_d2;
  logic [2:0] done_type;
  logic       emit;

  assign is_rt     = (byte_in[7:3] == 5'b11111);
  // Program Change (0xC) and Channel Aftertouch (0xD) carry a single data byte.
  assign two_bytes = !((run_q[6:4] == 3'd4) || (run_q[6:4] == 3'd5));

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    d1_d    = d1_q;
    done    = 1'b0;
    done_d1 = 7'd0;
    done_d2 = 7'd0;
    if (byte_in_valid && !is_rt) begin
      if (byte_in[7]) begin
        if (byte_in[7:4] != 4'hF) begin
          run_d   = byte_in;
          state_d = WAIT_D1;
        end else begin
          run_d   = 8'd0;
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: ;
          WAIT_D1: begin
            d1_d = byte_in[6:0];
            if (two_bytes) begin
              state_d = WAIT_D2;
            end else begin
              done    = 1'b1;
              done_d1 = byte_in[6:0];
            end
          end
          WAIT_D2: begin
            done    = 1'b1;
            done_d1 = d1_q;
            done_d2 = byte_in[6:0];
            state_d = WAIT_D1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    done_type = run_q[6:4];
    if (VEL0_AS_OFF && (run_q[6:4] == 3'd1) && (done_d2 == 7'd0)) begin
      done_type = 3'd0;
    end
    emit = done && (OMNI || (run_q[3:0] == CHANNEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 8'd0;
      d1_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      d1_q    <= d1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_valid <= 1'b0;
      msg_type  <= 3'd0;
      msg_chan  <= 4'd0;
      msg_data1 <= 7'd0;
      msg_data2 <= 7'd0;
      drop_cnt  <= 8'd0;
    end else if (emit) begin
      // A transfer in the same cycle frees the register, so no bubble.
      if (!msg_valid || msg_ready) begin
        msg_valid <= 1'b1;
        msg_type  <= done_type;
        msg_chan  <= run_q[3:0];
        msg_data1 <= done_d1;
        msg_data2 <= done_d2;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (msg_valid && msg_ready) begin
      msg_valid <= 1'b0;
    end
  end

endmodule
